// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS-subset control sequencer: decodes the IR and issues per-state datapath control.
// Optional performance counters are built when MCTRL_PERF_EN is defined.
module multicycle_ctrl #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             run,
   input  logic [31:0]      Instruction,
   input  logic             Zero,
   output logic             PCWr,
   output logic [1:0]       PCSrc,
   output logic             IRWr,
   output logic             RegWr,
   output logic             RegDst,
   output logic             ExtOp,
   output logic             ALUSrc,
   output logic [2:0]       ALUctr,
   output logic             MemWr,
   output logic             MemtoReg,
   output logic [2:0]       state,
   output logic             err,
   output logic [CNT_W-1:0] cyc_cnt,
   output logic [CNT_W-1:0] ret_cnt
);

   typedef enum logic [2:0] {
      S_IF  = 3'd0,
      S_ID  = 3'd1,
      S_EX  = 3'd2,
      S_MEM = 3'd3,
      S_WB  = 3'd4,
      S_ERR = 3'd7
   } state_t;

   typedef enum logic [2:0] {
      K_RTYPE, K_LW, K_SW, K_BEQ, K_J, K_ADDI, K_ORI, K_BAD
   } kind_t;

   state_t     cur, nxt;
   kind_t      kind;
   logic [2:0] r_aluctr;
   logic       r_ok;
   logic       pc_wr, ir_wr, reg_wr, mem_wr;
   logic       unused_bits;

   assign unused_bits = ^Instruction[25:6];

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      r_ok     = 1'b1;
      r_aluctr = 3'b000;
      case (Instruction[5:0])
         6'b100000: r_aluctr = 3'b000;
         6'b100010: r_aluctr = 3'b001;
         6'b100100: r_aluctr = 3'b010;
         6'b100101: r_aluctr = 3'b011;
         6'b101010: r_aluctr = 3'b100;
         default:   r_ok     = 1'b0;
      endcase

      kind = K_BAD;
      case (Instruction[31:26])
         6'b000000: kind = r_ok ? K_RTYPE : K_BAD;
         6'b100011: kind = K_LW;
         6'b101011: kind = K_SW;
         6'b000100: kind = K_BEQ;
         6'b000010: kind = K_J;
         6'b001000: kind = K_ADDI;
         6'b001101: kind = K_ORI;
         default:   kind = K_BAD;
      endcase
   end

   always_comb begin
      nxt = cur;
      if (run) begin
         case (cur)
            S_IF:    nxt = S_ID;
            S_ID:    nxt = (kind == K_BAD) ? S_ERR : (kind == K_J) ? S_IF : S_EX;
            S_EX:    nxt = (kind == K_BEQ) ? S_IF :
                           (kind == K_LW || kind == K_SW) ? S_MEM : S_WB;
            S_MEM:   nxt = (kind == K_LW) ? S_WB : S_IF;
            S_WB:    nxt = S_IF;
            S_ERR:   nxt = S_ERR;
            default: nxt = S_IF;
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments; reset is asynchronous so rst acts mid-cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) cur <= S_IF;
      else     cur <= nxt;
   end

   // WB recomputes the EX-cycle ALU settings from the still-held IR.
   always_comb begin
      pc_wr    = 1'b0;
      ir_wr    = 1'b0;
      reg_wr   = 1'b0;
      mem_wr   = 1'b0;
      PCSrc    = 2'b00;
      RegDst   = 1'b0;
      ExtOp    = 1'b0;
      ALUSrc   = 1'b0;
      ALUctr   = 3'b000;
      MemtoReg = 1'b0;
      case (cur)
         S_IF: begin
            pc_wr = 1'b1;
            ir_wr = 1'b1;
         end
         S_ID: begin
            if (kind == K_J) begin
               pc_wr = 1'b1;
               PCSrc = 2'b10;
            end
         end
         S_EX, S_WB: begin
            case (kind)
               K_RTYPE:            ALUctr = r_aluctr;
               K_ADDI, K_LW, K_SW: begin ALUSrc = 1'b1; ExtOp = 1'b1; end
               K_ORI:              begin ALUSrc = 1'b1; ALUctr = 3'b011; end
               K_BEQ:              ALUctr = 3'b001;
               default:            ALUctr = 3'b000;
            endcase
            if (cur == S_EX && kind == K_BEQ) begin
               PCSrc = 2'b01;
               pc_wr = Zero;
            end
            if (cur == S_WB) begin
               reg_wr   = 1'b1;
               RegDst   = (kind == K_RTYPE);
               MemtoReg = (kind == K_LW);
            end
         end
         S_MEM:   mem_wr = (kind == K_SW);
         default: ;
      endcase
   end

   assign PCWr  = pc_wr  & run & ~rst;
   assign IRWr  = ir_wr  & run & ~rst;
   assign RegWr = reg_wr & run & ~rst;
   assign MemWr = mem_wr & run & ~rst;
   assign state = cur;
   assign err   = (cur == S_ERR);

`ifdef MCTRL_PERF_EN
   logic [CNT_W-1:0] cyc_q, ret_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cyc_q <= '0;
         ret_q <= '0;
      end else if (run) begin
         if (cur != S_ERR)               cyc_q <= cyc_q + CNT_W'(1);
         if (nxt == S_IF && cur != S_IF) ret_q <= ret_q + CNT_W'(1);
      end
   end

   assign cyc_cnt = cyc_q;
   assign ret_cnt = ret_q;
`else
   assign cyc_cnt = '0;
   assign ret_cnt = '0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: per-cycle state/control checks for each instruction class,
// run stalls, illegal-instruction trap and asynchronous reset.
module tb_multicycle_ctrl;

   logic        clk = 1'b0;
   logic        rst, run, Zero;
   logic [31:0] Instruction;
   logic        PCWr, IRWr, RegWr, RegDst, ExtOp, ALUSrc, MemWr, MemtoReg, err;
   logic [1:0]  PCSrc;
   logic [2:0]  ALUctr, state;
   logic [31:0] cyc_cnt, ret_cnt;
   logic [12:0] ctl;

`ifdef MCTRL_PERF_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   int n_tests = 0;
   int n_fail  = 0;
   int exp_cyc = 0;
   int exp_ret = 0;

   multicycle_ctrl #(.CNT_W(32)) dut (
      .clk(clk), .rst(rst), .run(run), .Instruction(Instruction), .Zero(Zero),
      .PCWr(PCWr), .PCSrc(PCSrc), .IRWr(IRWr), .RegWr(RegWr), .RegDst(RegDst),
      .ExtOp(ExtOp), .ALUSrc(ALUSrc), .ALUctr(ALUctr), .MemWr(MemWr),
      .MemtoReg(MemtoReg), .state(state), .err(err),
      .cyc_cnt(cyc_cnt), .ret_cnt(ret_cnt)
   );

   always #5 clk = ~clk;

   assign ctl = {PCWr, PCSrc, IRWr, RegWr, RegDst, ExtOp, ALUSrc, ALUctr, MemWr, MemtoReg};

   function automatic logic [12:0] cw(input int pcwr, input int pcsrc, input int irwr,
                                      input int regwr, input int regdst, input int extop,
                                      input int alusrc, input int aluctr, input int memwr,
                                      input int memtoreg);
      return {pcwr[0], pcsrc[1:0], irwr[0], regwr[0], regdst[0], extop[0], alusrc[0],
              aluctr[2:0], memwr[0], memtoreg[0]};
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // One clock cycle: check mid-cycle, then advance the bench's counter model across the edge.
   task automatic step(input string tag, input int st, input logic [12:0] exp_ctl, input bit last);
      @(negedge clk);
      check({tag, " state"}, state, st);
      check({tag, " ctl"}, ctl, exp_ctl);
      check({tag, " err"}, err, st == 7);
      @(posedge clk);
      if (run && st != 7) exp_cyc++;
      if (run && last)    exp_ret++;
      #1;
   endtask

   task automatic check_cnt(input string tag);
      check({tag, " cyc_cnt"}, cyc_cnt, PERF ? exp_cyc : 0);
      check({tag, " ret_cnt"}, ret_cnt, PERF ? exp_ret : 0);
   endtask

   task automatic reset_pulse(input string tag);
      rst = 1'b1;
      #1;
      check({tag, " state"}, state, 0);
      check({tag, " err"}, err, 0);
      check({tag, " ctl"}, ctl, '0);
      exp_cyc = 0;
      exp_ret = 0;
      check_cnt(tag);
      @(posedge clk);
      #1 rst = 1'b0;
   endtask

   logic [31:0] rt_ins [4] = '{32'h00221822, 32'h0022182A, 32'h00221824, 32'h00221825};
   logic [2:0]  rt_alu [4] = '{3'b001, 3'b100, 3'b010, 3'b011};

   initial begin
      #200000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1);
   end

   initial begin
      logic [12:0] c_if;
      c_if = cw(1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
      rst = 1'b1; run = 1'b1; Zero = 1'b0; Instruction = 32'h0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset state", state, 0);
      check("reset ctl", ctl, '0);
      check("reset err", err, 0);
      check_cnt("reset");
      @(posedge clk);
      #1 rst = 1'b0;

      // add with Zero high throughout: Zero must be ignored outside beq EX
      Instruction = 32'h00221820; Zero = 1'b1;
      step("add IF", 0, c_if, 0);
      step("add ID", 1, '0, 0);
      step("add EX", 2, '0, 0);
      step("add WB", 4, cw(0, 0, 0, 1, 1, 0, 0, 0, 0, 0), 1);
      check_cnt("add");
      Zero = 1'b0;

      for (int i = 0; i < 4; i++) begin
         Instruction = rt_ins[i];
         step("rtype IF", 0, c_if, 0);
         step("rtype ID", 1, '0, 0);
         step("rtype EX", 2, cw(0, 0, 0, 0, 0, 0, 0, rt_alu[i], 0, 0), 0);
         step("rtype WB", 4, cw(0, 0, 0, 1, 1, 0, 0, rt_alu[i], 0, 0), 1);
      end

      Instruction = 32'h8C220004;
      step("lw IF", 0, c_if, 0);
      step("lw ID", 1, '0, 0);
      step("lw EX", 2, cw(0, 0, 0, 0, 0, 1, 1, 0, 0, 0), 0);
      step("lw MEM", 3, '0, 0);
      step("lw WB", 4, cw(0, 0, 0, 1, 0, 1, 1, 0, 0, 1), 1);
      check_cnt("lw");

      Instruction = 32'h20220005;
      step("addi IF", 0, c_if, 0);
      step("addi ID", 1, '0, 0);
      step("addi EX", 2, cw(0, 0, 0, 0, 0, 1, 1, 0, 0, 0), 0);
      step("addi WB", 4, cw(0, 0, 0, 1, 0, 1, 1, 0, 0, 0), 1);

      Instruction = 32'h34220005;
      step("ori IF", 0, c_if, 0);
      step("ori ID", 1, '0, 0);
      step("ori EX", 2, cw(0, 0, 0, 0, 0, 0, 1, 3, 0, 0), 0);
      step("ori WB", 4, cw(0, 0, 0, 1, 0, 0, 1, 3, 0, 0), 1);

      Instruction = 32'h10220003; Zero = 1'b1;
      step("beq1 IF", 0, c_if, 0);
      step("beq1 ID", 1, '0, 0);
      step("beq1 EX", 2, cw(1, 1, 0, 0, 0, 0, 0, 1, 0, 0), 1);
      Zero = 1'b0;
      step("beq0 IF", 0, c_if, 0);
      step("beq0 ID", 1, '0, 0);
      step("beq0 EX", 2, cw(0, 1, 0, 0, 0, 0, 0, 1, 0, 0), 1);

      Instruction = 32'h08000010;
      step("j IF", 0, c_if, 0);
      step("j ID", 1, cw(1, 2, 0, 0, 0, 0, 0, 0, 0, 0), 1);
      check_cnt("j");

      Instruction = 32'hAC220004;
      step("sw IF", 0, c_if, 0);
      step("sw ID", 1, '0, 0);
      step("sw EX", 2, cw(0, 0, 0, 0, 0, 1, 1, 0, 0, 0), 0);
      run = 1'b0;
      repeat (3) step("sw stall", 3, '0, 0);
      run = 1'b1;
      step("sw MEM", 3, cw(0, 0, 0, 0, 0, 0, 0, 0, 1, 0), 1);
      check_cnt("sw");

      Instruction = 32'hFC000000;
      step("ill IF", 0, c_if, 0);
      step("ill ID", 1, '0, 0);
      for (int i = 0; i < 4; i++) begin
         Zero = i[0];
         step("ill ERR", 7, '0, 0);
      end
      check_cnt("ill");
      reset_pulse("ill rst");

      Instruction = 32'h00000000;
      step("badfn IF", 0, c_if, 0);
      step("badfn ID", 1, '0, 0);
      step("badfn ERR", 7, '0, 0);
      reset_pulse("badfn rst");

      Instruction = 32'h00221820;
      step("rstex IF", 0, c_if, 0);
      step("rstex ID", 1, '0, 0);
      #1 check("rstex pre state", state, 2);
      rst = 1'b1;
      #1;
      check("rstex state", state, 0);
      check("rstex ctl", ctl, '0);
      exp_cyc = 0;
      exp_ret = 0;
      check_cnt("rstex");
      @(posedge clk);
      #1 rst = 1'b0;

      step("post IF", 0, c_if, 0);
      step("post ID", 1, '0, 0);
      step("post EX", 2, '0, 0);
      step("post WB", 4, cw(0, 0, 0, 1, 1, 0, 0, 0, 0, 0), 1);
      check_cnt("post");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
